// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port.
// State is registered; strobes are combinational from state, and FETCH/MEM_RD/MEM_WR hold until mem_ack.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] op_alu,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] FN_ADD  = 6'b100000;

  localparam logic [1:0] SRC_B_RT    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [5:0] ALU_SUM  = 6'd0;
  localparam logic [5:0] ALU_ADDI = 6'd1;
  localparam logic [5:0] ALU_LW   = 6'd2;
  localparam logic [5:0] ALU_SW   = 6'd3;
  localparam logic [5:0] ALU_BEQ  = 6'd4;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    EXEC_I   = 4'd5,
    WB_I     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    WB_MEM   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  assign state = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    op_alu     = ALU_SUM;
    retire     = 1'b0;
    illegal    = 1'b0;

    unique case (cur_state)
      IDLE: begin
        nxt_state = FETCH;
      end

      FETCH: begin
        // PC+4 is computed every wait cycle but only committed on the ack edge
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          nxt_state = DECODE;
        end
      end

      DECODE: begin
        alu_src_b = SRC_B_IMMSH;
        unique case (op)
          OP_R:        nxt_state = (funct == FN_ADD) ? EXEC_R : TRAP;
          OP_ADDI:     nxt_state = EXEC_I;
          OP_LW, OP_SW: nxt_state = MEM_ADDR;
          OP_BEQ:      nxt_state = BRANCH;
          OP_J:        nxt_state = JUMP;
          default:     nxt_state = TRAP;
        endcase
      end

      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_RT;
        nxt_state = WB_R;
      end

      WB_R: begin
        reg_we    = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        nxt_state = FETCH;
      end

      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        op_alu    = ALU_ADDI;
        nxt_state = WB_I;
      end

      WB_I: begin
        reg_we    = 1'b1;
        retire    = 1'b1;
        nxt_state = FETCH;
      end

      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        if (op == OP_LW) begin
          op_alu    = ALU_LW;
          nxt_state = MEM_RD;
        end else if (op == OP_SW) begin
          op_alu    = ALU_SW;
          nxt_state = MEM_WR;
        end else begin
          // op changed under us after DECODE; refuse to guess
          nxt_state = TRAP;
        end
      end

      MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ack) begin
          nxt_state = WB_MEM;
        end
      end

      WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        nxt_state  = FETCH;
      end

      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ack) begin
          retire    = 1'b1;
          nxt_state = FETCH;
        end
      end

      BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_RT;
        op_alu    = ALU_BEQ;
        pc_src    = PC_ALUOUT;
        pc_we     = zero;
        retire    = 1'b1;
        nxt_state = FETCH;
      end

      JUMP: begin
        pc_src    = PC_JUMP;
        pc_we     = 1'b1;
        retire    = 1'b1;
        nxt_state = FETCH;
      end

      TRAP: begin
        illegal   = 1'b1;
        nxt_state = TRAP;
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

endmodule
